// File: rtl/team_06_effect_proc.sv
// Transmit-path voice effect processor: echo/reverb delay line, tremolo LFO,
// soft attenuation, and mute while listening. One output per sample strobe.
module team_06_effect_proc #(
  parameter int DEPTH    = 64,
  parameter int TREM_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] mic_aud,
  input  logic       state,
  input  logic [2:0] current_effect,
  output logic [7:0] out_aud,
  output logic       out_valid,
  output logic       eff_active
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;

  localparam logic [2:0] EFF_ECHO   = 3'b001;
  localparam logic [2:0] EFF_TREM   = 3'b010;
  localparam logic [2:0] EFF_REVERB = 3'b011;
  localparam logic [2:0] EFF_SOFT   = 3'b100;

  logic signed [7:0] dly [DEPTH];
  logic [AW-1:0]     wp;
  logic [3:0]        g;
  logic              dir_up;
  logic [CW-1:0]     cnt;
  logic [2:0]        prev_effect;

  logic signed [7:0]  s8, d8, y8, wr8;
  logic signed [9:0]  s10, d10, sum10;
  logic signed [12:0] s13, g13, prod13, trem13;
  logic               trem_entry;
  logic [3:0]         g_eff;
  logic               dir_eff;
  logic [CW-1:0]      cnt_eff;
  logic               is_effect;

  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'sd127;
    else if (v < -10'sd128) return -8'sd128;
    else                    return v[7:0];
  endfunction

  assign s8  = $signed({~mic_aud[7], mic_aud[6:0]});
  assign d8  = dly[wp];
  assign s10 = {{2{s8[7]}}, s8};
  assign d10 = {{2{d8[7]}}, d8};
  assign s13 = {{5{s8[7]}}, s8};

  // Entering tremolo restarts the LFO before this sample uses the gain
  assign trem_entry = state && (current_effect == EFF_TREM) && (prev_effect != EFF_TREM);
  assign g_eff      = trem_entry ? 4'd15 : g;
  assign dir_eff    = trem_entry ? 1'b0 : dir_up;
  assign cnt_eff    = trem_entry ? '0 : cnt;

  assign is_effect = (current_effect == EFF_ECHO) || (current_effect == EFF_TREM) ||
                     (current_effect == EFF_REVERB) || (current_effect == EFF_SOFT);

  always_comb begin
    sum10  = s10 + (d10 >>> 1);
    g13    = $signed({9'b0, g_eff});
    prod13 = s13 * g13;
    trem13 = prod13 >>> 4;
    y8     = s8;
    wr8    = s8;
    if (!state) begin
      y8  = '0;
      wr8 = '0;
    end else begin
      case (current_effect)
        EFF_ECHO:   y8 = sat8(sum10);
        EFF_TREM:   y8 = trem13[7:0];
        EFF_REVERB: begin
          y8  = sat8(sum10);
          wr8 = sat8(sum10);
        end
        EFF_SOFT:   y8 = s8 >>> 1;
        default:    y8 = s8;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_aud     <= 8'd128;
      out_valid   <= 1'b0;
      eff_active  <= 1'b0;
      wp          <= '0;
      g           <= 4'd15;
      dir_up      <= 1'b0;
      cnt         <= '0;
      prev_effect <= 3'b000;
      for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
    end else begin
      out_valid  <= sample_valid;
      eff_active <= state && is_effect;
      if (sample_valid) begin
        out_aud     <= {~y8[7], y8[6:0]};
        dly[wp]     <= wr8;
        wp          <= wp + AW'(1);
        prev_effect <= current_effect;
        // Triangle LFO: 15 down to 0, back up to 15, stepping every TREM_DIV samples
        if (state && (current_effect == EFF_TREM)) begin
          if (cnt_eff == CW'(TREM_DIV - 1)) begin
            cnt <= '0;
            if (!dir_eff) begin
              if (g_eff == 4'd0) begin
                dir_up <= 1'b1;
                g      <= 4'd1;
              end else begin
                dir_up <= 1'b0;
                g      <= g_eff - 4'd1;
              end
            end else begin
              if (g_eff == 4'd15) begin
                dir_up <= 1'b0;
                g      <= 4'd14;
              end else begin
                dir_up <= 1'b1;
                g      <= g_eff + 4'd1;
              end
            end
          end else begin
            cnt    <= cnt_eff + CW'(1);
            g      <= g_eff;
            dir_up <= dir_eff;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_team_06_effect_proc.sv
// Scoreboard bench for team_06_effect_proc: a queue-based delay/triangle-gain
// reference model predicts each output; a monitor checks value and timing.
module tb_team_06_effect_proc;

  localparam int DEPTH    = 8;
  localparam int TREM_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] mic_aud = 8'd128;
  logic       state = 1'b0;
  logic [2:0] current_effect = 3'b000;
  logic [7:0] out_aud;
  logic       out_valid;
  logic       eff_active;

  team_06_effect_proc #(.DEPTH(DEPTH), .TREM_DIV(TREM_DIV)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .mic_aud(mic_aud),
    .state(state), .current_effect(current_effect),
    .out_aud(out_aud), .out_valid(out_valid), .eff_active(eff_active)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int val; } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  logic exp_eff;

  // Reference model state: history of written values, tremolo sample count
  int hist[$];
  int n_trem;
  int m_prev;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) exp_eff <= 1'b0;
    else     exp_eff <= state && (current_effect >= 3'd1) && (current_effect <= 3'd4);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int tri_gain(input int step);
    int t = step % 30;
    return (t <= 15) ? 15 - t : t - 15;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(0);
    n_trem = 0;
    m_prev = 0;
  endtask

  task automatic model_step(input logic st, input logic [2:0] eff, input logic [7:0] mic,
                            output int outv);
    int s, d, y, w;
    s = int'(mic) - 128;
    d = hist.pop_front();
    if (!st) begin
      y = 0; w = 0;
    end else begin
      case (int'(eff))
        1: begin y = sat(s + (d >>> 1)); w = s; end
        2: begin
          if (m_prev != 2) n_trem = 0;
          y = (s * tri_gain(n_trem / TREM_DIV)) >>> 4;
          n_trem++;
          w = s;
        end
        3: begin y = sat(s + (d >>> 1)); w = y; end
        4: begin y = s >>> 1; w = s; end
        default: begin y = s; w = s; end
      endcase
    end
    m_prev = int'(eff);
    hist.push_back(w);
    outv = y + 128;
  endtask

  // Drive one cycle of inputs; every strobe pushes its predicted output
  task automatic applyStimulus(input logic v, input logic st, input logic [2:0] eff,
                               input logic [7:0] mic);
    int e;
    exp_t item;
    sample_valid   = v;
    state          = st;
    current_effect = eff;
    mic_aud        = mic;
    if (v) begin
      model_step(st, eff, mic, e);
      item.cyc = cycle + 1;
      item.val = e;
      sbq.push_back(item);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("eff_active", int'(eff_active), int'(exp_eff));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_out_valid", 1, 0);
        end else begin
          exp_t it;
          it = sbq.pop_front();
          checkOutput("out_latency", cycle, it.cyc);
          checkOutput("out_aud", int'(out_aud), it.val);
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cycle) begin
        exp_t it;
        it = sbq.pop_front();
        checkOutput("missing_out_valid", 0, 1);
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_out_aud", int'(out_aud), 128);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_eff_active", int'(eff_active), 0);
    @(posedge clk);
    #1;

    $display("[TB] normal and listen");
    applyStimulus(1, 1, 3'd0, 8'd200);
    applyStimulus(1, 1, 3'd0, 8'd10);
    applyStimulus(0, 1, 3'd0, 8'd10);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 3'd1, 8'd255);

    $display("[TB] echo impulse and saturation");
    applyStimulus(1, 1, 3'd1, 8'd228);
    for (int i = 0; i < 2 * DEPTH + 2; i++) applyStimulus(1, 1, 3'd1, 8'd128);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1, 1, 3'd1, 8'd255);

    $display("[TB] reverb impulse and flush");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 3'd3, 8'd128);
    applyStimulus(1, 1, 3'd3, 8'd228);
    for (int i = 0; i < 3 * DEPTH + 2; i++) applyStimulus(1, 1, 3'd3, 8'd128);
    applyStimulus(1, 1, 3'd3, 8'd228);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 3'd3, 8'd128);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 1, 3'd3, 8'd128);

    $display("[TB] tremolo");
    for (int i = 0; i < 35 * TREM_DIV; i++) applyStimulus(1, 1, 3'd2, 8'd228);
    applyStimulus(1, 1, 3'd4, 8'd228);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 3'd2, 8'd20);

    $display("[TB] soft and mid-stream reset");
    applyStimulus(1, 1, 3'd4, 8'd0);
    applyStimulus(1, 1, 3'd4, 8'd255);
    applyStimulus(1, 1, 3'd4, 8'd129);
    applyStimulus(0, 1, 3'd4, 8'd129);
    applyStimulus(1, 1, 3'd4, 8'd0);
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_out_aud", int'(out_aud), 128);
    rst = 1'b0;
    sbq.delete();
    model_reset();
    sample_valid = 1'b1;
    mic_aud      = 8'd0;
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pending_dropped", int'(out_valid), 0);
    checkOutput("pending_out_aud", int'(out_aud), 128);

    $display("[TB] randomized traffic");
    begin
      logic       st  = 1'b1;
      logic [2:0] eff = 3'd1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 19) == 0) st  = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 14) == 0) eff = 3'($urandom_range(0, 7));
        applyStimulus($urandom_range(0, 9) < 7, st, eff, 8'($urandom_range(0, 255)));
      end
    end

    repeat (3) applyStimulus(0, 0, 3'd0, 8'd128);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/team_06_effect_proc.md
Name: team_06_effect_proc

Overview:
- Applies the selected voice effect to the transmit (mic) audio path. Sits directly downstream of the team_06 talk/listen control FSM.
- Consumes that FSM's `state` (LIST=0/TALK=1) and `current_effect` (3-bit code) and processes one 8-bit offset-binary mic sample per `sample_valid` strobe.
- Produces the processed sample toward the output/DAC stage.
- Keeps a circular delay line for echo/reverb and a triangle LFO for tremolo.

Parameters:
- DEPTH, 64, delay-line length in samples; power of two, ≥4.
- TREM_DIV, 256, number of valid samples per tremolo LFO step; ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sample_valid  in  1  one-cycle strobe; mic_aud is valid this cycle
- mic_aud  in  8  mic sample, offset binary (128 = silence)
- state  in  1  0 = LIST, 1 = TALK
- current_effect  in  3  000 NORMAL, 001 ECHO, 010 TREMOLO, 011 REVERB, 100 SOFT; others treated as NORMAL
- out_aud  out  8  processed sample, offset binary
- out_valid  out  1  one-cycle strobe; out_aud updated
- eff_active  out  1  registered; 1 when state=1 and current_effect ∈ {001..100}

Behaviour:
- Reset (async, rst=1) drives every register to its reset value:
  - out_aud = 128, out_valid = 0, eff_active = 0.
  - All delay-line entries = 0 (signed), write pointer wp = 0.
  - LFO gain g = 15, direction = down, LFO sample counter = 0.
  - prev_effect = 000.
- Latency:
  - out_valid asserts exactly 1 cycle after each sample_valid, for 1 cycle; out_aud is registered at that same edge.
  - Back-to-back sample_valid is legal; one output per input, none dropped.
- Arithmetic:
  - Signed input s = mic_aud − 128 (invert MSB).
  - Intermediates are computed at ≥10 bits signed.
  - Result y is saturated to [−128, 127]; out_aud = y + 128.
  - All shifts are arithmetic (floor toward −∞).
- Delay line: on each sample_valid, d = buf[wp] is read; buf[wp] is written at the same edge; wp = (wp+1) mod DEPTH. d is therefore the value written DEPTH samples earlier.
- Effect behaviour when state = 1:
  - NORMAL / undefined codes: y = s; write s.
  - ECHO: y = sat(s + (d >>> 1)); write s (feed-forward).
  - TREMOLO: y = (s × g) >>> 4; write s.
  - REVERB: y = sat(s + (d >>> 1)); write y (feedback).
  - SOFT: y = s >>> 1; write s.
- state = 0 (LIST), on each sample_valid:
  - out_aud = 128, out_valid still pulses.
  - buf[wp] is written with 0 (flush) and wp advances.
  - LFO holds.
- LFO:
  - Advances only on sample_valid while state=1 and current_effect=010.
  - The counter counts valid samples; at TREM_DIV−1 it wraps to 0 and g steps by 1.
  - Triangle between 15 and 0: down from 15, reverse at 0, up to 15, reverse.
  - Entering TREMOLO (current_effect=010 while prev_effect≠010, sampled on sample_valid) resets g=15, direction down, counter=0 before the sample is processed.
- prev_effect updates on every sample_valid. An effect change takes effect on the next sample_valid; the delay line is not cleared on effect change.
- `state` and `current_effect` are sampled only on sample_valid cycles. Changes between strobes have no effect until the next strobe. eff_active updates every cycle.
- Reset mid-stream: asynchronous clear takes effect immediately. out_valid drops the same cycle and no pending output is emitted.

Test Plan:
1. Reset, state=1, effect=000, mic_aud 200 then 10 → out_aud 200 then 10. Each out_valid is exactly 1 cycle after its strobe.
2. state=0, mic_aud=255 strobes → out_aud=128 each time with out_valid pulsing. eff_active=0.
3. ECHO, DEPTH=64: impulse mic_aud=228 (s=100), then 128s → out 228; sample 64 later out=178 (128+50); sample 128 later out=128. Saturation check: s=127 with d=127 → out 255.
4. REVERB: same impulse → outputs 228, then 178 at +64, 153 at +128, 140 at +192 (100→50→25→12). Switching state to 0 for 64 strobes and back → no residual tail.
5. TREMOLO, TREM_DIV=1: constant mic_aud=228 → out 221 (g=15, 93), then 215 (g=14, 87), and so on down to 128 at g=0, then rising. Switch away and back → restarts at 221.
6. SOFT: mic_aud=0 → out 64; mic_aud=255 → out 191; mic_aud=129 → out 128. Assert rst between two strobes → out_aud 128, out_valid 0 immediately.
